// File: rtl/colour_detect_multi.sv
// Frame-level RGB dominance classifier with per-colour hysteresis flags.
// Optional COLOUR_COUNT_OUT_EN exposes the latched per-frame counts.

module colour_ch #(
    parameter int COUNT_W   = 20,
    parameter int THRESHOLD = 100,
    parameter int HYST      = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cnt_en,
    input  logic               fin,
    input  logic               hit,
`ifdef COLOUR_COUNT_OUT_EN
    output logic [COUNT_W-1:0] final_cnt,
`endif
    output logic               flag
);
    localparam logic [COUNT_W-1:0] SET_LVL = COUNT_W'(THRESHOLD);
    localparam logic [COUNT_W-1:0] CLR_LVL = COUNT_W'(THRESHOLD - HYST);

    logic [COUNT_W-1:0] cnt_q, cnt_nxt;

    // cnt_nxt already includes the current beat, so finalise sees the eop pixel
    always_comb begin
        cnt_nxt = cnt_q;
        if (start)
            cnt_nxt = {{(COUNT_W-1){1'b0}}, hit};
        else if (cnt_en && hit && (cnt_q != {COUNT_W{1'b1}}))
            cnt_nxt = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            flag  <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (fin) begin
                if (cnt_nxt >= SET_LVL)
                    flag <= 1'b1;
                else if (cnt_nxt < CLR_LVL)
                    flag <= 1'b0;
            end
        end
    end

`ifdef COLOUR_COUNT_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   final_cnt <= '0;
        else if (fin) final_cnt <= cnt_nxt;
    end
`endif
endmodule

module colour_detect_multi #(
    parameter int CH_W      = 4,
    parameter int MARGIN    = 2,
    parameter int THRESHOLD = 100,
    parameter int HYST      = 10,
    parameter int COUNT_W   = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3*CH_W-1:0]   pixel,
    input  logic                valid,
    input  logic                sop,
    input  logic                eop,
`ifdef COLOUR_COUNT_OUT_EN
    output logic [COUNT_W-1:0]  red_count,
    output logic [COUNT_W-1:0]  green_count,
    output logic [COUNT_W-1:0]  blue_count,
`endif
    output logic [2:0]          colour_flags,
    output logic                frame_done,
    output logic                frame_err,
    output logic                busy
);
    localparam logic [CH_W:0] M = (CH_W+1)'(MARGIN);

    typedef enum logic {IDLE, IN_FRAME} state_t;
    state_t state_q, state_nxt;

    // index 2 = R, 1 = G, 0 = B, matching colour_flags order
    logic [2:0][CH_W:0] ch;
    logic [2:0]         dom_raw, hit;
    logic               start, cnt_en, fin, err;

    always_comb begin
        for (int k = 0; k < 3; k++)
            ch[k] = {1'b0, pixel[k*CH_W +: CH_W]};
        dom_raw[2] = (ch[2] >= ch[1] + M) && (ch[2] >= ch[0] + M);
        dom_raw[1] = (ch[1] >= ch[2] + M) && (ch[1] >= ch[0] + M);
        dom_raw[0] = (ch[0] >= ch[2] + M) && (ch[0] >= ch[1] + M);
        // ties only possible with MARGIN=0; R beats G beats B
        hit[2] = dom_raw[2];
        hit[1] = dom_raw[1] & ~dom_raw[2];
        hit[0] = dom_raw[0] & ~dom_raw[2] & ~dom_raw[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:     if (valid && sop && !eop) state_nxt = IN_FRAME;
            IN_FRAME: if (valid && eop)         state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start  = 1'b0;
        cnt_en = 1'b0;
        fin    = 1'b0;
        err    = 1'b0;
        busy   = (state_q == IN_FRAME);
        if (valid) begin
            if (sop) begin
                start = 1'b1;
                fin   = eop;
                err   = (state_q == IN_FRAME);
            end else if (state_q == IN_FRAME) begin
                cnt_en = 1'b1;
                fin    = eop;
            end else begin
                err = eop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= fin;
            frame_err  <= err;
        end
    end

`ifdef COLOUR_COUNT_OUT_EN
    logic [2:0][COUNT_W-1:0] fcnt;
    assign red_count   = fcnt[2];
    assign green_count = fcnt[1];
    assign blue_count  = fcnt[0];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_ch
        colour_ch #(
            .COUNT_W  (COUNT_W),
            .THRESHOLD(THRESHOLD),
            .HYST     (HYST)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .cnt_en   (cnt_en),
            .fin      (fin),
            .hit      (hit[g]),
`ifdef COLOUR_COUNT_OUT_EN
            .final_cnt(fcnt[g]),
`endif
            .flag     (colour_flags[g])
        );
    end
endmodule

// File: tb/tb_colour_detect_multi.sv
// Bench for colour_detect_multi: frame table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_colour_detect_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pixel;
    logic        valid, sop, eop;
    logic [2:0]  colour_flags, flags1;
    logic        frame_done, frame_err, busy;
    logic        done1, err1, busy1;
`ifdef COLOUR_COUNT_OUT_EN
    logic [19:0] rc, gc, bc, rc1, gc1, bc1;
`endif

    always #5 clk = ~clk;

    colour_detect_multi dut (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .valid(valid), .sop(sop), .eop(eop),
`ifdef COLOUR_COUNT_OUT_EN
        .red_count(rc), .green_count(gc), .blue_count(bc),
`endif
        .colour_flags(colour_flags), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    colour_detect_multi #(.THRESHOLD(1), .HYST(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .valid(valid), .sop(sop), .eop(eop),
`ifdef COLOUR_COUNT_OUT_EN
        .red_count(rc1), .green_count(gc1), .blue_count(bc1),
`endif
        .colour_flags(flags1), .frame_done(done1), .frame_err(err1), .busy(busy1)
    );

    typedef struct {
        logic [11:0] pix_a;
        int          n_a;
        logic [11:0] pix_b;
        int          n_b;
        bit          alt;
        logic [2:0]  exp_flags;
    } frame_vec_t;

    int         n_cmp = 0, n_fail = 0;
    int         done_cnt = 0, err_cnt = 0;
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every frame_done must match the oldest queued expectation
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'(frame_done), 32'd0);
            else                   chk("flags_at_done", 32'(colour_flags), 32'(exp_q.pop_front()));
        end
        if (frame_err) err_cnt++;
    end

    task automatic beat(input logic [11:0] p, input logic v, input logic s, input logic e);
        pixel = p; valid = v; sop = s; eop = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(12'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input frame_vec_t f);
        int tot, lastv;
        logic v;
        tot   = f.n_a + f.n_b;
        lastv = f.alt ? ((tot - 1) & ~1) : tot - 1;
        exp_q.push_back(f.exp_flags);
        for (int i = 0; i < tot; i++) begin
            v = f.alt ? (i % 2 == 0) : 1'b1;
            beat((i < f.n_a) ? f.pix_a : f.pix_b, v, (i == 0), (i == lastv));
            if (i == 0)     chk("busy_in_frame", 32'(busy), 32'd1);
            if (i == lastv) begin
                chk("done_latency", 32'(frame_done), 32'd1);
                chk("busy_after_eop", 32'(busy), 32'd0);
            end
        end
        idle(1);
        chk("done_one_cycle", 32'(frame_done), 32'd0);
    endtask

    frame_vec_t vecs[7];
    int         d0, e0;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pixel = '0; valid = 0; sop = 0; eop = 0;
        vecs[0] = '{12'hF11, 101, 12'h111, 0,  1'b0, 3'b100};
        vecs[1] = '{12'hF11, 95,  12'h111, 6,  1'b0, 3'b100};
        vecs[2] = '{12'hF11, 89,  12'h111, 11, 1'b0, 3'b000};
        vecs[3] = '{12'h311, 100, 12'h111, 0,  1'b0, 3'b100};
        vecs[4] = '{12'h211, 100, 12'h111, 0,  1'b0, 3'b000};
        vecs[5] = '{12'h1F1, 100, 12'h111, 0,  1'b0, 3'b010};
        vecs[6] = '{12'h1F1, 100, 12'h111, 0,  1'b1, 3'b000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 32'(colour_flags), 32'd0);
        chk("rst_done",  32'(frame_done),   32'd0);
        chk("rst_err",   32'(frame_err),    32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // eop with valid low must not finalise
        d0 = done_cnt; e0 = err_cnt;
        beat(12'hF11, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("invalid_eop_no_done", 32'(done_cnt), 32'(d0));
        chk("invalid_eop_no_err",  32'(err_cnt),  32'(e0));

        // eop in IDLE: error pulse, flags held
        run_frame(vecs[0]);
        e0 = err_cnt;
        beat(12'hF11, 1'b1, 1'b0, 1'b1);
        chk("idle_eop_err", 32'(frame_err), 32'd1);
        chk("idle_eop_flags", 32'(colour_flags), 32'b100);
        idle(1);
        chk("idle_eop_err_pulse", 32'(frame_err), 32'd0);
        chk("idle_eop_err_cnt", 32'(err_cnt), 32'(e0 + 1));

        // restart: 60 red pixels discarded, 80 counted -> red clears
        exp_q.push_back(3'b000);
        beat(12'hF11, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) beat(12'hF11, 1'b1, 1'b0, 1'b0);
        beat(12'hF11, 1'b1, 1'b1, 1'b0);
        chk("restart_err", 32'(frame_err), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 78; i++) beat(12'hF11, 1'b1, 1'b0, 1'b0);
        chk("restart_err_pulse", 32'(frame_err), 32'd0);
        beat(12'hF11, 1'b1, 1'b0, 1'b1);
        chk("restart_done", 32'(frame_done), 32'd1);
        idle(1);

        // one-pixel frame; THRESHOLD=1 instance sets blue
        exp_q.push_back(3'b000);
        beat(12'h11F, 1'b1, 1'b1, 1'b1);
        chk("single_done", 32'(frame_done), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_th1_done", 32'(done1), 32'd1);
        chk("single_th1_flags", 32'(flags1), 32'b001);
        idle(1);

        // async reset mid-frame, then orphan eop
        run_frame(vecs[0]);
        beat(12'hF11, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) beat(12'hF11, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", 32'(colour_flags), 32'd0);
        chk("async_rst_busy",  32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) beat(12'hF11, 1'b1, 1'b0, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        beat(12'hF11, 1'b1, 1'b0, 1'b1);
        chk("post_rst_eop_err", 32'(frame_err), 32'd1);
        idle(2);
        chk("post_rst_no_done", 32'(done_cnt), 32'(d0));
        chk("post_rst_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        chk("post_rst_flags", 32'(colour_flags), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
